// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter arbiter: byte width, FSM encoding and
// grant-index width helper.
package uart_pkg;

    localparam int unsigned UART_BYTE_W = 8;

    typedef enum logic [1:0] {
        ARB_IDLE      = 2'd0,
        ARB_START     = 2'd1,
        ARB_WAIT_BUSY = 2'd2,
        ARB_WAIT_DONE = 2'd3
    } arb_state_e;

    // A single requester still needs a 1-bit index.
    function automatic int unsigned grant_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request strictly after 'last', wrapping,
// built as a double-width masked priority encoder.
module rr_pick
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned GRANT_W = grant_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GRANT_W-1:0] last,
    output logic [NUM_REQ-1:0] grant,
    output logic [GRANT_W-1:0] grant_idx,
    output logic               any
);

    logic [NUM_REQ-1:0]   mask;
    logic [2*NUM_REQ-1:0] dbl;

    always_comb begin
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            mask[i] = (i > int'(last));
        end
        // Low half holds requests above the pointer, high half the wrapped-around set.
        dbl = {req, req & mask};

        grant_idx = '0;
        for (int i = 2 * int'(NUM_REQ) - 1; i >= 0; i--) begin
            if (dbl[i]) begin
                grant_idx = (i >= int'(NUM_REQ)) ? GRANT_W'(i - int'(NUM_REQ)) : GRANT_W'(i);
            end
        end

        any = |req;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            grant[i] = any && (grant_idx == GRANT_W'(i));
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte producers,
// with a sticky flag for a transmitter that never raises BUSY after START.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned START_TIMEOUT = 16,
    localparam int unsigned GRANT_W      = grant_width(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [UART_BYTE_W*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]             req_ack,
    output logic                           tx_start,
    output logic [UART_BYTE_W-1:0]         tx_data,
    input  logic                           tx_busy,
    output logic [GRANT_W-1:0]             grant_id,
    output logic                           active,
    output logic                           timeout_err,
    input  logic                           err_clr
);

    localparam int unsigned TIMER_W = $clog2(START_TIMEOUT);

    arb_state_e             state_q, state_d;
    logic [NUM_REQ-1:0]     ack_q, ack_d;
    logic                   start_q, start_d;
    logic [UART_BYTE_W-1:0] data_q, data_d;
    logic [GRANT_W-1:0]     grant_q, grant_d;
    logic [GRANT_W-1:0]     last_q, last_d;
    logic [TIMER_W-1:0]     timer_q, timer_d;
    logic                   err_q, err_d;
    logic                   active_q, active_d;

    logic [NUM_REQ-1:0]     pick_grant;
    logic [GRANT_W-1:0]     pick_idx;
    logic                   pick_any;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .GRANT_W (GRANT_W)
    ) u_rr_pick (
        .req       (req),
        .last      (last_q),
        .grant     (pick_grant),
        .grant_idx (pick_idx),
        .any       (pick_any)
    );

    always_comb begin
        state_d = state_q;
        ack_d   = '0;
        start_d = 1'b0;
        data_d  = data_q;
        grant_d = grant_q;
        last_d  = last_q;
        timer_d = timer_q;
        err_d   = err_q;
        if (err_clr) begin
            err_d = 1'b0;
        end

        case (state_q)
            ARB_IDLE: begin
                // A busy transmitter in IDLE belongs to someone else; do not stack a START on it.
                if (pick_any && !tx_busy) begin
                    data_d  = req_data[UART_BYTE_W*pick_idx +: UART_BYTE_W];
                    grant_d = pick_idx;
                    last_d  = pick_idx;
                    ack_d   = pick_grant;
                    start_d = 1'b1;
                    timer_d = '0;
                    state_d = ARB_START;
                end
            end
            ARB_START: begin
                state_d = ARB_WAIT_BUSY;
            end
            ARB_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = ARB_WAIT_DONE;
                end else if (timer_q == TIMER_W'(START_TIMEOUT - 1)) begin
                    // Byte is dropped; the pointer already moved so fairness is preserved.
                    err_d   = 1'b1;
                    state_d = ARB_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ARB_WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase

        active_d = (state_d != ARB_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ARB_IDLE;
            ack_q    <= '0;
            start_q  <= 1'b0;
            data_q   <= '0;
            grant_q  <= '0;
            last_q   <= GRANT_W'(NUM_REQ - 1);
            timer_q  <= '0;
            err_q    <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ack_q    <= ack_d;
            start_q  <= start_d;
            data_q   <= data_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            timer_q  <= timer_d;
            err_q    <= err_d;
            active_q <= active_d;
        end
    end

    assign req_ack     = ack_q;
    assign tx_start    = start_q;
    assign tx_data     = data_q;
    assign grant_id    = grant_q;
    assign active      = active_q;
    assign timeout_err = err_q;

endmodule
